// File: rtl/myuart_reg_fifo.sv
// APB register front-end for the myuart TX/RX engines with parametrised TX/RX FIFOs,
// overrun/parity status, RX level threshold, FIFO flush and a maskable interrupt.
module myuart_reg_fifo #(
    parameter int          TX_AW   = 3,
    parameter int          RX_AW   = 3,
    parameter logic [15:0] DIV_RST = 16'd868,
    parameter logic [7:0]  OVS_RST = 8'd16
) (
    input  logic        pclk_i,
    input  logic        preset_n_i,
    input  logic        psel_i,
    input  logic        penable_i,
    input  logic        pwrite_i,
    input  logic [5:0]  paddr_i,
    input  logic [31:0] pwdata_i,
    output logic [31:0] prdata_o,
    output logic        shoot_o,
    output logic [7:0]  datatx_o,
    input  logic        busytx_i,
    input  logic        datarx_vld_i,
    input  logic [7:0]  datarx_i,
    input  logic        int_parity_error_i,
    output logic        interrupt_o,
    output logic [3:0]  data_bit_num_o,
    output logic [1:0]  parity_type_o,
    output logic [1:0]  stop_bit_num_o,
    output logic [15:0] divisor_o,
    output logic [7:0]  oversample_rate_o
);
    localparam logic [5:0] A_CR   = 6'h04;
    localparam logic [5:0] A_THR  = 6'h08;
    localparam logic [5:0] A_SR   = 6'h0C;
    localparam logic [5:0] A_BRGR = 6'h10;
    localparam logic [5:0] A_IMR  = 6'h14;
    localparam logic [5:0] A_FCR  = 6'h18;

    localparam logic [TX_AW:0]   TX_FULL = {1'b1, {TX_AW{1'b0}}};
    localparam logic [RX_AW:0]   RX_FULL = {1'b1, {RX_AW{1'b0}}};
    localparam logic [TX_AW:0]   TX_ONE  = {{TX_AW{1'b0}}, 1'b1};
    localparam logic [RX_AW:0]   RX_ONE  = {{RX_AW{1'b0}}, 1'b1};
    localparam logic [TX_AW-1:0] TX_PINC = {{(TX_AW-1){1'b0}}, 1'b1};
    localparam logic [RX_AW-1:0] RX_PINC = {{(RX_AW-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_LOAD = 2'd1, S_WBSY = 2'd2, S_WDONE = 2'd3} tx_state_t;

    tx_state_t        r_state;
    logic [9:0]       r_cr;
    logic [23:0]      r_brgr;
    logic [5:0]       r_imr;
    logic [RX_AW:0]   r_rxt;
    logic             r_ovr;
    logic             r_pare;
    logic             r_shoot;
    logic [7:0]       r_datatx;

    logic [7:0]       r_tx_mem [2**TX_AW];
    logic [TX_AW-1:0] r_tx_wp, r_tx_rp;
    logic [TX_AW:0]   r_tx_cnt;
    logic [7:0]       r_rx_mem [2**RX_AW];
    logic [RX_AW-1:0] r_rx_wp, r_rx_rp;
    logic [RX_AW:0]   r_rx_cnt;

    logic        w_wr, w_rd, w_tx_en;
    logic        w_tx_empty, w_tx_full, w_tx_push, w_tx_pop, w_tx_ovr, w_tx_flush;
    logic        w_rx_empty, w_rx_full, w_rx_push, w_rx_pop, w_rx_ovr, w_rx_flush;
    logic        w_rxthr, w_txempty;
    logic [31:0] w_sr;

    assign w_wr    = psel_i & penable_i & pwrite_i;
    assign w_rd    = psel_i & penable_i & ~pwrite_i;
    assign w_tx_en = r_cr[0];

    assign w_tx_empty = (r_tx_cnt == {(TX_AW+1){1'b0}});
    assign w_tx_full  = (r_tx_cnt == TX_FULL);
    assign w_tx_flush = w_wr & (paddr_i == A_FCR) & pwdata_i[0];
    assign w_tx_push  = w_wr & (paddr_i == A_THR) & ~w_tx_full;
    assign w_tx_ovr   = w_wr & (paddr_i == A_THR) & w_tx_full;
    assign w_tx_pop   = (r_state == S_LOAD) & w_tx_en & ~w_tx_empty;

    assign w_rx_empty = (r_rx_cnt == {(RX_AW+1){1'b0}});
    assign w_rx_full  = (r_rx_cnt == RX_FULL);
    assign w_rx_flush = w_wr & (paddr_i == A_FCR) & pwdata_i[1];
    assign w_rx_pop   = w_rd & (paddr_i == A_THR) & ~w_rx_empty;
    // A full RX FIFO still accepts a byte when the head is popped in the same cycle.
    assign w_rx_push  = datarx_vld_i & (~w_rx_full | w_rx_pop) & ~w_rx_flush;
    assign w_rx_ovr   = datarx_vld_i & w_rx_full & ~w_rx_pop & ~w_rx_flush;

    assign w_rxthr   = (r_rxt != {(RX_AW+1){1'b0}}) && (r_rx_cnt >= r_rxt);
    assign w_txempty = w_tx_empty & (r_state == S_IDLE) & ~busytx_i;
    assign w_sr      = {8'd0, 8'(r_rx_cnt), 8'(r_tx_cnt), 2'b00, r_pare, r_ovr,
                        w_rxthr, w_txempty, ~w_tx_full, ~w_rx_empty};

    assign interrupt_o       = |(r_imr & w_sr[5:0]);
    assign shoot_o           = r_shoot;
    assign datatx_o          = r_datatx;
    assign data_bit_num_o    = r_cr[7:4];
    assign parity_type_o     = r_cr[2:1];
    assign stop_bit_num_o    = r_cr[9:8];
    assign divisor_o         = r_brgr[15:0];
    assign oversample_rate_o = r_brgr[23:16];

    // Read mux.
    always_comb begin
        prdata_o = 32'd0;
        case (paddr_i)
            A_CR:    prdata_o = {22'd0, r_cr};
            A_THR:   prdata_o = w_rx_empty ? 32'd0 : {24'd0, r_rx_mem[r_rx_rp]};
            A_SR:    prdata_o = w_sr;
            A_BRGR:  prdata_o = {8'd0, r_brgr};
            A_IMR:   prdata_o = {26'd0, r_imr};
            A_FCR:   prdata_o = {{(23-RX_AW){1'b0}}, r_rxt, 8'd0};
            default: prdata_o = 32'd0;
        endcase
    end

    // Configuration registers and sticky status; a set event wins over W1C.
    always_ff @(posedge pclk_i or negedge preset_n_i) begin
        if (!preset_n_i) begin
            r_cr   <= 10'h081;
            r_brgr <= {OVS_RST, DIV_RST};
            r_imr  <= 6'd0;
            r_rxt  <= RX_ONE;
            r_ovr  <= 1'b0;
            r_pare <= 1'b0;
        end else begin
            if (w_wr && paddr_i == A_CR)   r_cr   <= pwdata_i[9:0];
            if (w_wr && paddr_i == A_BRGR) r_brgr <= pwdata_i[23:0];
            if (w_wr && paddr_i == A_IMR)  r_imr  <= pwdata_i[5:0];
            if (w_wr && paddr_i == A_FCR)  r_rxt  <= pwdata_i[8 +: RX_AW+1];
            if (w_tx_ovr || w_rx_ovr)
                r_ovr <= 1'b1;
            else if (w_wr && paddr_i == A_SR && pwdata_i[4])
                r_ovr <= 1'b0;
            if (int_parity_error_i)
                r_pare <= 1'b1;
            else if (w_wr && paddr_i == A_SR && pwdata_i[5])
                r_pare <= 1'b0;
        end
    end

    // TX FIFO storage.
    always_ff @(posedge pclk_i) begin
        if (w_tx_push) r_tx_mem[r_tx_wp] <= pwdata_i[7:0];
    end

    // TX FIFO pointers and count.
    always_ff @(posedge pclk_i or negedge preset_n_i) begin
        if (!preset_n_i) begin
            r_tx_wp <= '0; r_tx_rp <= '0; r_tx_cnt <= '0;
        end else if (w_tx_flush) begin
            r_tx_wp <= '0; r_tx_rp <= '0; r_tx_cnt <= '0;
        end else begin
            if (w_tx_push) r_tx_wp <= r_tx_wp + TX_PINC;
            if (w_tx_pop)  r_tx_rp <= r_tx_rp + TX_PINC;
            case ({w_tx_push, w_tx_pop})
                2'b10:   r_tx_cnt <= r_tx_cnt + TX_ONE;
                2'b01:   r_tx_cnt <= r_tx_cnt - TX_ONE;
                default: r_tx_cnt <= r_tx_cnt;
            endcase
        end
    end

    // RX FIFO storage.
    always_ff @(posedge pclk_i) begin
        if (w_rx_push) r_rx_mem[r_rx_wp] <= datarx_i;
    end

    // RX FIFO pointers and count.
    always_ff @(posedge pclk_i or negedge preset_n_i) begin
        if (!preset_n_i) begin
            r_rx_wp <= '0; r_rx_rp <= '0; r_rx_cnt <= '0;
        end else if (w_rx_flush) begin
            r_rx_wp <= '0; r_rx_rp <= '0; r_rx_cnt <= '0;
        end else begin
            if (w_rx_push) r_rx_wp <= r_rx_wp + RX_PINC;
            if (w_rx_pop)  r_rx_rp <= r_rx_rp + RX_PINC;
            case ({w_rx_push, w_rx_pop})
                2'b10:   r_rx_cnt <= r_rx_cnt + RX_ONE;
                2'b01:   r_rx_cnt <= r_rx_cnt - RX_ONE;
                default: r_rx_cnt <= r_rx_cnt;
            endcase
        end
    end

    // TX handshake FSM; LOAD falls back to IDLE if a flush emptied the FIFO under it.
    always_ff @(posedge pclk_i or negedge preset_n_i) begin
        if (!preset_n_i) begin
            r_state  <= S_IDLE;
            r_shoot  <= 1'b0;
            r_datatx <= 8'd0;
        end else begin
            r_shoot <= 1'b0;
            if (w_tx_en) begin
                case (r_state)
                    S_IDLE:  if (!w_tx_empty && !busytx_i) r_state <= S_LOAD;
                    S_LOAD: begin
                        if (!w_tx_empty) begin
                            r_datatx <= r_tx_mem[r_tx_rp];
                            r_shoot  <= 1'b1;
                            r_state  <= S_WBSY;
                        end else begin
                            r_state  <= S_IDLE;
                        end
                    end
                    S_WBSY:  if (busytx_i) r_state <= S_WDONE;
                    S_WDONE: if (!busytx_i) r_state <= S_IDLE;
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_myuart_reg_fifo.sv
// Scoreboard bench for myuart_reg_fifo: TX bytes checked on shoot_o, RX bytes on RHR reads.
module tb_myuart_reg_fifo;
    localparam logic [5:0] A_CR = 6'h04, A_THR = 6'h08, A_SR = 6'h0C;
    localparam logic [5:0] A_BRGR = 6'h10, A_IMR = 6'h14, A_FCR = 6'h18;

    logic        pclk_i = 1'b0;
    logic        preset_n_i = 1'b0;
    logic        psel_i = 1'b0, penable_i = 1'b0, pwrite_i = 1'b0;
    logic [5:0]  paddr_i = 6'd0;
    logic [31:0] pwdata_i = 32'd0;
    logic [31:0] prdata_o;
    logic        shoot_o;
    logic [7:0]  datatx_o;
    logic        busytx_i = 1'b0;
    logic        datarx_vld_i = 1'b0;
    logic [7:0]  datarx_i = 8'd0;
    logic        int_parity_error_i = 1'b0;
    logic        interrupt_o;
    logic [3:0]  data_bit_num_o;
    logic [1:0]  parity_type_o, stop_bit_num_o;
    logic [15:0] divisor_o;
    logic [7:0]  oversample_rate_o;

    myuart_reg_fifo dut (
        .pclk_i(pclk_i), .preset_n_i(preset_n_i), .psel_i(psel_i), .penable_i(penable_i),
        .pwrite_i(pwrite_i), .paddr_i(paddr_i), .pwdata_i(pwdata_i), .prdata_o(prdata_o),
        .shoot_o(shoot_o), .datatx_o(datatx_o), .busytx_i(busytx_i),
        .datarx_vld_i(datarx_vld_i), .datarx_i(datarx_i),
        .int_parity_error_i(int_parity_error_i), .interrupt_o(interrupt_o),
        .data_bit_num_o(data_bit_num_o), .parity_type_o(parity_type_o),
        .stop_bit_num_o(stop_bit_num_o), .divisor_o(divisor_o),
        .oversample_rate_o(oversample_rate_o)
    );

    always #5 pclk_i = ~pclk_i;

    int n_cmp = 0, n_err = 0;
    int shots = 0, tmr = 0;
    logic [7:0] txq[$], rxq[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // TX core model: checks each shoot_o against the scoreboard, then busy after a short delay.
    always @(negedge pclk_i) begin
        if (!preset_n_i) begin
            tmr = 0;
            busytx_i = 1'b0;
        end else begin
            if (tmr > 0) tmr--;
            busytx_i = (tmr > 0 && tmr <= 3);
            if (shoot_o) begin
                shots++;
                if (txq.size() == 0) check_eq("tx_unexpected_shoot", 32'(txq.size()), 32'd1);
                else check_eq("tx_byte", {24'd0, datatx_o}, {24'd0, txq.pop_front()});
                tmr = 6;
            end
        end
    end

    task automatic apb(input bit wr, input logic [5:0] a, input logic [31:0] wd,
                       input bit sv, input logic [7:0] sb, input bit sp, output logic [31:0] rd);
        @(posedge pclk_i); #1;
        psel_i = 1'b1; penable_i = 1'b0; pwrite_i = wr; paddr_i = a; pwdata_i = wd;
        @(posedge pclk_i); #1;
        penable_i = 1'b1; datarx_vld_i = sv; datarx_i = sb; int_parity_error_i = sp;
        @(negedge pclk_i);
        rd = prdata_o;
        @(posedge pclk_i); #1;
        psel_i = 1'b0; penable_i = 1'b0; pwrite_i = 1'b0;
        datarx_vld_i = 1'b0; int_parity_error_i = 1'b0;
    endtask

    task automatic wr(input logic [5:0] a, input logic [31:0] d);
        logic [31:0] dummy;
        apb(1'b1, a, d, 1'b0, 8'd0, 1'b0, dummy);
    endtask

    task automatic rdc(input string tag, input logic [5:0] a, input logic [31:0] exp);
        logic [31:0] v;
        apb(1'b0, a, 32'd0, 1'b0, 8'd0, 1'b0, v);
        check_eq(tag, v, exp);
    endtask

    task automatic rhr_pop(input string tag);
        logic [31:0] v;
        apb(1'b0, A_THR, 32'd0, 1'b0, 8'd0, 1'b0, v);
        check_eq(tag, v, {24'd0, rxq.pop_front()});
    endtask

    task automatic rx_strobe(input logic [7:0] b);
        @(posedge pclk_i); #1;
        datarx_vld_i = 1'b1; datarx_i = b;
        @(posedge pclk_i); #1;
        datarx_vld_i = 1'b0;
    endtask

    task automatic wait_tx_idle(input string tag);
        int n;
        n = 0;
        while (n < 300 && !(txq.size() == 0 && tmr == 0)) begin
            @(negedge pclk_i);
            n++;
        end
        check_eq(tag, 32'(n < 300), 32'd1);
    endtask

    initial begin
        logic [31:0] v;
        int n, shots_rst;
        repeat (3) @(posedge pclk_i);
        check_eq("rst_shoot", {31'd0, shoot_o}, 32'd0);
        check_eq("rst_datatx", {24'd0, datatx_o}, 32'd0);
        check_eq("rst_irq", {31'd0, interrupt_o}, 32'd0);
        #1 preset_n_i = 1'b1;
        rdc("rst_cr", A_CR, 32'h081);
        rdc("rst_brgr", A_BRGR, 32'h0010_0364);
        rdc("rst_imr", A_IMR, 32'd0);
        rdc("rst_fcr", A_FCR, 32'h100);
        rdc("rst_sr", A_SR, 32'h06);
        check_eq("cfg_outs", {16'd0, data_bit_num_o, parity_type_o, stop_bit_num_o, oversample_rate_o},
                 32'h0000_8010);
        check_eq("divisor", {16'd0, divisor_o}, 32'd868);
        wr(6'h1C, 32'hFFFF_FFFF);
        rdc("unmapped", 6'h1C, 32'd0);

        // Two-byte transmit with latency check on the first byte.
        txq.push_back(8'h55); txq.push_back(8'hAA);
        wr(A_THR, 32'h55);
        @(negedge pclk_i); check_eq("lat_c0", {31'd0, shoot_o}, 32'd0);
        @(negedge pclk_i); check_eq("lat_c1", {31'd0, shoot_o}, 32'd0);
        @(negedge pclk_i); check_eq("lat_c2", {31'd0, shoot_o}, 32'd1);
        wr(A_THR, 32'hAA);
        wait_tx_idle("tx2_timeout");
        repeat (3) @(negedge pclk_i);
        check_eq("tx2_shots", 32'(shots), 32'd2);
        rdc("tx2_sr", A_SR, 32'h06);

        // TX overrun with the FSM disabled.
        wr(A_CR, 32'h080);
        for (int i = 0; i < 9; i++) wr(A_THR, 32'h60 + 32'(i));
        rdc("txfull_sr", A_SR, 32'h0810);
        wr(A_SR, 32'h10);
        rdc("ovr_w1c", A_SR, 32'h0800);
        wr(A_FCR, 32'h101);
        rdc("txflush_sr", A_SR, 32'h06);
        wr(A_CR, 32'h081);

        // RX threshold interrupt and in-order reads.
        wr(A_FCR, 32'h200);
        rdc("fcr_rxt2", A_FCR, 32'h200);
        wr(A_IMR, 32'h08);
        rxq.push_back(8'h11); rx_strobe(8'h11);
        check_eq("irq_after1", {31'd0, interrupt_o}, 32'd0);
        rxq.push_back(8'h22); rx_strobe(8'h22);
        check_eq("irq_after2", {31'd0, interrupt_o}, 32'd1);
        rxq.push_back(8'h33); rx_strobe(8'h33);
        rdc("rx3_sr", A_SR, 32'h0003_000F);
        for (int i = 0; i < 3; i++) rhr_pop("rhr_order");
        rdc("rhr_empty", A_THR, 32'd0);
        check_eq("irq_drained", {31'd0, interrupt_o}, 32'd0);

        // RX full with a push coincident with a pop, then a real RX overrun.
        wr(A_FCR, 32'h0);
        wr(A_IMR, 32'h0);
        for (int i = 0; i < 8; i++) begin
            rxq.push_back(8'h40 + 8'(i));
            rx_strobe(8'h40 + 8'(i));
        end
        rdc("rxfull_sr", A_SR, 32'h0008_0007);
        apb(1'b0, A_THR, 32'd0, 1'b1, 8'h48, 1'b0, v);
        check_eq("rhr_coinc", v, {24'd0, rxq.pop_front()});
        rxq.push_back(8'h48);
        rdc("coinc_sr", A_SR, 32'h0008_0007);
        rx_strobe(8'h49);
        rdc("rxovr_sr", A_SR, 32'h0008_0017);
        wr(A_SR, 32'h10);
        for (int i = 0; i < 8; i++) rhr_pop("rhr_drain");

        // Parity set wins over a coincident W1C; flush both FIFOs.
        apb(1'b1, A_SR, 32'h20, 1'b0, 8'd0, 1'b1, v);
        rdc("pare_set", A_SR, 32'h26);
        wr(A_SR, 32'h20);
        rdc("pare_clr", A_SR, 32'h06);
        wr(A_CR, 32'h080);
        wr(A_THR, 32'h77); wr(A_THR, 32'h78);
        rx_strobe(8'h99); rx_strobe(8'h9A);
        rdc("preflush_sr", A_SR, 32'h0002_0203);
        wr(A_FCR, 32'h3);
        rdc("flush_sr", A_SR, 32'h06);

        // Reset while the FSM waits in WBSY with three bytes still queued.
        for (int i = 0; i < 4; i++) begin
            txq.push_back(8'hA1 + 8'(i));
            wr(A_THR, 32'hA1 + 32'(i));
        end
        wr(A_CR, 32'h081);
        n = 0;
        while (n < 50 && !shoot_o) begin
            @(negedge pclk_i);
            n++;
        end
        check_eq("wbsy_shoot_seen", 32'(n < 50), 32'd1);
        @(negedge pclk_i);
        preset_n_i = 1'b0;
        #1;
        txq.delete();
        shots_rst = shots;
        check_eq("midrst_shoot", {31'd0, shoot_o}, 32'd0);
        check_eq("midrst_datatx", {24'd0, datatx_o}, 32'd0);
        repeat (2) @(posedge pclk_i);
        #1 preset_n_i = 1'b1;
        rdc("midrst_sr", A_SR, 32'h06);
        repeat (30) @(negedge pclk_i);
        check_eq("midrst_noshoot", 32'(shots), 32'(shots_rst));
        rdc("midrst_cr", A_CR, 32'h081);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
